// File: rtl/fp_mul_result_packer_if.sv
// Handshake bundle between the multiplier analyzers, the result packer and the downstream consumer.
interface fp_mul_result_packer_if #(
    parameter bit IS_DOUBLE = 1'b0
);
    localparam int unsigned EXP_WIDTH  = IS_DOUBLE ? 11 : 8;
    localparam int unsigned MANT_WIDTH = IS_DOUBLE ? 52 : 23;
    localparam int unsigned PW         = 2 * MANT_WIDTH + 2;
    localparam int unsigned WW         = EXP_WIDTH + 2;
    localparam int unsigned RW         = EXP_WIDTH + MANT_WIDTH + 1;

    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [WW-1:0] in_exp;
    logic [PW-1:0] in_mant;
    logic [3:0]    in_status;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic [3:0]    out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_status, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_status, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_mul_result_packer.sv
// FP multiplier output stage: bit-serial normalize, round-to-nearest-even, pack result and flags.
// Define FP_MUL_FTZ_EN to flush subnormal results to zero (no DENORM state).
module fp_mul_result_packer #(
    parameter bit IS_DOUBLE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp_mul_result_packer_if.slave  bus
);
    localparam int unsigned EXP_WIDTH  = IS_DOUBLE ? 11 : 8;
    localparam int unsigned MANT_WIDTH = IS_DOUBLE ? 52 : 23;
    localparam int unsigned PW         = 2 * MANT_WIDTH + 2;
    localparam int unsigned WW         = EXP_WIDTH + 2;
    localparam int unsigned RW         = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int unsigned KW         = MANT_WIDTH + 1;

    localparam logic signed [WW-1:0] W_ONE = WW'(1);
    localparam logic signed [WW-1:0] W_MAX = WW'((1 << EXP_WIDTH) - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] NORM   = 3'd1;
`ifndef FP_MUL_FTZ_EN
    localparam logic [2:0] DENORM = 3'd2;
`endif
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic signed [WW-1:0] w_q, w_d;
    logic [PW-1:0]        p_q, p_d;
    logic                 s_q, s_d;
    logic                 sign_q, sign_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [RW-1:0]        out_result_q, out_result_d;
    logic [3:0]           out_flags_q, out_flags_d;

    // Rounding datapath, consumed only in ROUND
    logic [KW-1:0]        k, k_rnd;
    logic [KW:0]          k_sum;
    logic                 g, t, up, inexact, ovf;
    logic signed [WW-1:0] w_rnd;
    logic [EXP_WIDTH-1:0] e_fld;

    always_comb begin
        k       = p_q[PW-1 -: KW];
        g       = p_q[PW-2-MANT_WIDTH];
        t       = s_q | (|p_q[PW-3-MANT_WIDTH:0]);
        up      = g & (t | k[0]);
        inexact = g | t;
        k_sum   = {1'b0, k} + (KW+1)'(up);
        if (k_sum[KW]) begin
            k_rnd = k_sum[KW:1];
            w_rnd = w_q + W_ONE;
        end else begin
            k_rnd = k_sum[KW-1:0];
            w_rnd = w_q;
        end
        ovf   = (w_rnd >= W_MAX);
        e_fld = k_rnd[MANT_WIDTH] ? w_rnd[EXP_WIDTH-1:0] : '0;
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        p_d          = p_q;
        s_d          = s_q;
        sign_d       = sign_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d = bus.in_sign;
                    w_d    = bus.in_exp + W_ONE;
                    p_d    = bus.in_mant;
                    s_d    = 1'b0;
                    if (|bus.in_status) begin
                        state_d = DONE;
                        // Priority: invalid > nan > inf > zero
                        if (bus.in_status[0] || bus.in_status[3]) begin
                            out_result_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
                            out_flags_d  = {bus.in_status[0], 3'b000};
                        end else if (bus.in_status[2]) begin
                            out_result_d = {bus.in_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                            out_flags_d  = 4'b0000;
                        end else begin
                            out_result_d = {bus.in_sign, {(RW-1){1'b0}}};
                            out_flags_d  = 4'b0000;
                        end
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (p_q[PW-1] || (w_q <= W_ONE)) begin
                    if (w_q < W_ONE) begin
`ifdef FP_MUL_FTZ_EN
                        state_d      = DONE;
                        out_result_d = {sign_q, {(RW-1){1'b0}}};
                        out_flags_d  = 4'b0011;
`else
                        state_d = DENORM;
`endif
                    end else begin
                        state_d = ROUND;
                    end
                end else begin
                    p_d = {p_q[PW-2:0], 1'b0};
                    w_d = w_q - W_ONE;
                end
            end
`ifndef FP_MUL_FTZ_EN
            DENORM: begin
                if (w_q == W_ONE) begin
                    state_d = ROUND;
                end else begin
                    s_d = s_q | p_q[0];
                    p_d = {1'b0, p_q[PW-1:1]};
                    w_d = w_q + W_ONE;
                    // Everything shifted out: only the sticky bit remains
                    if (p_q[PW-1:1] == '0) begin
                        w_d     = W_ONE;
                        state_d = ROUND;
                    end
                end
            end
`endif
            ROUND: begin
                state_d = DONE;
                if (ovf) begin
                    out_result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    out_flags_d  = 4'b0101;
`ifdef FP_MUL_FTZ_EN
                end else if (e_fld == '0) begin
                    out_result_d = {sign_q, {(RW-1){1'b0}}};
                    out_flags_d  = 4'b0011;
`endif
                end else begin
                    out_result_d = {sign_q, e_fld, k_rnd[MANT_WIDTH-1:0]};
                    out_flags_d  = {2'b00, (e_fld == '0) & inexact, inexact};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            w_q          <= '0;
            p_q          <= '0;
            s_q          <= 1'b0;
            sign_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            p_q          <= p_d;
            s_q          <= s_d;
            sign_q       <= sign_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
endmodule
